uart_xcvr: RTL
==============

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4167, clock cycles per bit; minimum 8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, RX FIFO entries; power of two, at least 2.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port tx_start, input, 1, transmit request, level-sensitive.
REQ-008 SHALL have port tx_data, input, DATA_W, transmit payload.
REQ-009 SHALL have port tx_busy, output, 1, transmitter occupied.
REQ-010 SHALL have port ser_tx, output, 1, serial line out, idles high.
REQ-011 SHALL have port ser_rx, input, 1, asynchronous serial line in.
REQ-012 SHALL have ports rx_valid (output, 1), rx_ready (input, 1) and rx_data (output, DATA_W), forming the RX FIFO head handshake.
REQ-013 SHALL have port rx_count, output, $clog2(FIFO_DEPTH+1), FIFO occupancy.
REQ-014 SHALL have ports rx_overrun, rx_frame_err and rx_parity_err, each output, 1, sticky error flags.
REQ-015 SHALL have port err_clear, input, 1, clears all sticky flags.

Function
REQ-016 TX FSM SHALL have states IDLE, START, DATA, PAR, STOP; each state SHALL last CLKS_PER_BIT cycles; PAR SHALL be skipped when PARITY=0.
REQ-017 TX SHALL accept a frame on the cycle where tx_start=1 and tx_busy=0, capturing tx_data in that cycle.
REQ-018 On acceptance, tx_busy SHALL rise on the next cycle, and the start bit (0) SHALL appear on ser_tx on that same next cycle.
REQ-019 TX data SHALL be sent LSB first; the parity bit SHALL give even or odd total ones over data+parity; the stop bit SHALL be 1 for one bit time.
REQ-020 tx_busy SHALL fall on the cycle after the stop bit ends.
REQ-021 If tx_start is still held when tx_busy falls, the next frame SHALL be accepted in that cycle, giving exactly a one-cycle high gap between frames.
REQ-022 ser_rx SHALL pass through a two-flop synchroniser before use.
REQ-023 RX FSM SHALL have states IDLE, START, DATA, PAR, STOP.
REQ-024 In IDLE, a falling edge on the synchronised line SHALL enter START.
REQ-025 START SHALL re-sample at CLKS_PER_BIT/2; a high value there SHALL be treated as a glitch and the FSM SHALL return to IDLE with no flag set.
REQ-026 DATA, PAR and STOP bits SHALL be sampled at bit centres, every CLKS_PER_BIT cycles after the confirmed start sample.
REQ-027 A stop-bit sample of 0 SHALL set rx_frame_err and discard the byte.
REQ-028 A parity mismatch SHALL set rx_parity_err and discard the byte.
REQ-029 A good byte SHALL be pushed to the FIFO one cycle after the stop sample, after which the RX FSM SHALL return to IDLE.
REQ-030 The FIFO SHALL be show-ahead: rx_valid = (rx_count != 0) and rx_data = head entry; a pop SHALL occur on rx_valid & rx_ready.
REQ-031 Push with FIFO full and no pop SHALL drop the byte and set rx_overrun; contents SHALL be unchanged.
REQ-032 Simultaneous push and pop while full SHALL succeed with no overrun; rx_count unchanged.
REQ-033 Simultaneous push and pop while empty SHALL update the count to 1 and leave rx_valid high; the pop is ignored because rx_valid was 0.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 err_clear SHALL clear the sticky flags next cycle; an error event in the same cycle SHALL win (flag set).
REQ-036 TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-037 resetb low SHALL immediately force: ser_tx=1, tx_busy=0, both FSMs IDLE, FIFO empty, rx_count=0, rx_valid=0, all flags 0, synchroniser flops 1.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no partial FIFO push; the next frame after release SHALL be received normally.

Structure
REQ-039 Package uart_pkg SHALL hold the parity-mode constants and the tx_state_t and rx_state_t enumerations.
REQ-040 The RX FIFO SHALL be the sub-module uart_rx_fifo, parametrised by DATA_W and FIFO_DEPTH.

Verification (bench: CLKS_PER_BIT=16, loopback ser_tx->ser_rx unless stated)
REQ-041 PARITY=0, send 8'h3D -> ser_tx shows 0,1,0,1,1,1,1,0,0,1 at 16-cycle steps; rx_data=8'h3D and rx_valid high 1 cycle after the stop sample.
REQ-042 PARITY=1, send 8'h07 then 8'h0F with tx_start held -> parity bits 1 then 0, 1-cycle gap between frames, both received in order.
REQ-043 FIFO_DEPTH=4, rx_ready=0, send 5 bytes 0x01..0x05 -> rx_count=4, rx_overrun=1, popped sequence is 01,02,03,04.
REQ-044 Drive ser_rx with a 6-cycle low pulse -> no push, no flags; then inject a stop bit of 0 -> rx_frame_err=1 and rx_count unchanged; err_clear -> flag 0.
REQ-045 Assert resetb low mid-data-bit of a TX frame -> ser_tx=1 and tx_busy=0 without waiting for a clock edge; after release, 8'hA5 loops back correctly.
REQ-046 PARITY=2, flip the received parity bit -> rx_parity_err=1 and byte discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM state types and parity helper shared by the UART transceiver
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  function automatic logic par_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : (mode == PAR_EVEN) ? ^d : 1'b0;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO with overrun detection
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               i_clock,
  input  logic                               i_resetb,
  input  logic                               i_push,
  input  logic [DATA_W-1:0]                  i_data,
  input  logic                               i_pop,
  output logic [DATA_W-1:0]                  o_data,
  output logic                               o_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
  output logic                               o_overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              w_pop, w_full, w_wr;
  assign o_valid   = r_cnt != '0;
  assign o_data    = r_mem[r_rp];
  assign o_count   = r_cnt;
  assign w_pop     = o_valid & i_pop;
  assign w_full    = r_cnt == CW'(FIFO_DEPTH);
  // a pop frees the slot in the same cycle, so push-while-full succeeds when popping
  assign w_wr      = i_push & (~w_full | w_pop);
  assign o_overrun = i_push & w_full & ~w_pop;
  always_ff @(posedge i_clock)
    if (w_wr) r_mem[r_wp] <= i_data;
  always_ff @(posedge i_clock or negedge i_resetb)
    if (!i_resetb) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: independent UART transmitter and receiver with RX FIFO and sticky error flags
module uart_xcvr import uart_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4167,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clock,
  input  logic                            resetb,
  input  logic                            tx_start,
  input  logic [DATA_W-1:0]               tx_data,
  output logic                            tx_busy,
  output logic                            ser_tx,
  input  logic                            ser_rx,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [DATA_W-1:0]               rx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            rx_overrun,
  output logic                            rx_frame_err,
  output logic                            rx_parity_err,
  input  logic                            err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

  tx_state_t         r_tx_state, w_tx_next;
  logic [CW-1:0]     r_tx_cnt;
  logic [BW-1:0]     r_tx_bit;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par, w_tx_tick;
  assign w_tx_tick = r_tx_cnt == LAST;
  assign tx_busy   = r_tx_state != TX_IDLE;
  assign ser_tx    = (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_shift[0] :
                     (r_tx_state == TX_PAR) ? r_tx_par : 1'b1;
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (tx_start) w_tx_next = TX_START;
      TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == BLAST) w_tx_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PAR;
      TX_PAR:   if (w_tx_tick) w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
      if (r_tx_state == TX_IDLE) begin
        r_tx_bit <= '0;
        if (tx_start) begin
          r_tx_shift <= tx_data;
          r_tx_par   <= par_bit(9'(tx_data), PARITY);
        end
      end else if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + BW'(1);
      end
    end

  rx_state_t         r_rx_state, w_rx_next;
  logic [1:0]        r_sync;
  logic              r_rx_prev, w_rx;
  logic [CW-1:0]     r_rx_cnt;
  logic [BW-1:0]     r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_par, r_push, w_rx_tick, w_rx_half, w_stop_smp, w_par_bad, w_ovr;
  logic              r_overrun, r_frame_err, r_parity_err;
  assign w_rx       = r_sync[1];
  assign w_rx_tick  = r_rx_cnt == LAST;
  assign w_rx_half  = r_rx_state == RX_START && r_rx_cnt == HALF;
  assign w_stop_smp = r_rx_state == RX_STOP && w_rx_tick;
  assign w_par_bad  = (PARITY != PAR_NONE) && (par_bit(9'(r_rx_shift), PARITY) != r_rx_par);
  assign rx_overrun    = r_overrun;
  assign rx_frame_err  = r_frame_err;
  assign rx_parity_err = r_parity_err;
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_next = RX_START;
      RX_START: if (w_rx_half) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == BLAST) w_rx_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PAR;
      RX_PAR:   if (w_rx_tick) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par     <= 1'b0;
      r_push       <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], ser_rx};
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_next;
      r_rx_cnt   <= (r_rx_state == RX_IDLE || w_rx_half || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      if (r_rx_state == RX_IDLE) r_rx_bit <= '0;
      else if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {w_rx, r_rx_shift[DATA_W-1:1]};
        r_rx_bit   <= r_rx_bit + BW'(1);
      end
      if (r_rx_state == RX_PAR && w_rx_tick) r_rx_par <= w_rx;
      r_push       <= w_stop_smp && w_rx && !w_par_bad;
      // a new error event overrides a simultaneous clear
      r_overrun    <= w_ovr | (r_overrun & ~err_clear);
      r_frame_err  <= (w_stop_smp && !w_rx) | (r_frame_err & ~err_clear);
      r_parity_err <= (w_stop_smp && w_par_bad) | (r_parity_err & ~err_clear);
    end

  uart_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock  (clock),
    .i_resetb (resetb),
    .i_push   (r_push),
    .i_data   (r_rx_shift),
    .i_pop    (rx_ready),
    .o_data   (rx_data),
    .o_valid  (rx_valid),
    .o_count  (rx_count),
    .o_overrun(w_ovr)
  );
endmodule
